// File: rtl/div_seq.sv
// div_seq: radix-2 restoring sequential divider (signed or unsigned per operation).
// Quotient on LO, remainder on HI; fixed WIDTH+1 cycle latency with start/done handshake.
module div_seq #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             DivStart,
   input  logic             DivSigned,
   input  logic [WIDTH-1:0] RegAOut,
   input  logic [WIDTH-1:0] RegBOut,
   output logic             DivBusy,
   output logic             DivDone,
   output logic             Div0,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

   function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] a);
      return (~a) + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] a, input logic sgn);
      return (sgn && a[WIDTH-1]) ? f_neg(a) : a;
   endfunction

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dsr;
   logic             r_qneg;
   logic             r_rneg;
   logic             r_busy;
   logic             r_done;
   logic             r_div0;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   // The stored remainder is always below the divisor, so WIDTH bits suffice;
   // only the shifted trial value needs the extra bit.
   logic [WIDTH:0]   w_shift_rem;
   logic [WIDTH:0]   w_diff;
   logic             w_ge;

   // One restoring step: shift in the next dividend bit and trial-subtract the divisor.
   always_comb begin
      w_shift_rem = {r_rem, r_quo[WIDTH-1]};
      w_diff      = w_shift_rem - {1'b0, r_dsr};
      w_ge        = ~w_diff[WIDTH];
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= {CNT_W{1'b0}};
         r_rem   <= ZERO_W;
         r_quo   <= ZERO_W;
         r_dsr   <= ZERO_W;
         r_qneg  <= 1'b0;
         r_rneg  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_div0  <= 1'b0;
         r_hi    <= ZERO_W;
         r_lo    <= ZERO_W;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (DivStart) begin
                  if (RegBOut == ZERO_W) begin
                     r_div0 <= 1'b1;
                     r_done <= 1'b1;
                     r_hi   <= ZERO_W;
                     r_lo   <= ZERO_W;
                  end else begin
                     r_quo   <= f_mag(RegAOut, DivSigned);
                     r_dsr   <= f_mag(RegBOut, DivSigned);
                     r_qneg  <= DivSigned & (RegAOut[WIDTH-1] ^ RegBOut[WIDTH-1]);
                     r_rneg  <= DivSigned & RegAOut[WIDTH-1];
                     r_rem   <= ZERO_W;
                     r_cnt   <= CNT_LOAD;
                     r_div0  <= 1'b0;
                     r_busy  <= 1'b1;
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift_rem[WIDTH-1:0];
               r_quo <= {r_quo[WIDTH-2:0], w_ge};
               r_cnt <= r_cnt - CNT_ONE;
               if (r_cnt == CNT_ONE) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               r_lo    <= r_qneg ? f_neg(r_quo) : r_quo;
               r_hi    <= r_rneg ? f_neg(r_rem) : r_rem;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign DivBusy = r_busy;
   assign DivDone = r_done;
   assign Div0    = r_div0;
   assign HI      = r_hi;
   assign LO      = r_lo;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq at WIDTH = 8, 16 and 32 against a plain-arithmetic model.
module tb_div_seq;

   logic        clk;
   logic        reset;
   int          cur_w;
   logic        g_start;
   logic        g_sgn;
   logic [63:0] g_a;
   logic [63:0] g_b;

   logic        g_busy, g_done, g_div0;
   logic [63:0] g_hi, g_lo;

   logic        s8, s16, s32;
   logic        busy8, busy16, busy32;
   logic        done8, done16, done32;
   logic        z8, z16, z32;
   logic [7:0]  hi8, lo8;
   logic [15:0] hi16, lo16;
   logic [31:0] hi32, lo32;

   int errors;
   int checks;

   assign s8  = g_start && (cur_w == 8);
   assign s16 = g_start && (cur_w == 16);
   assign s32 = g_start && (cur_w == 32);

   div_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset(reset), .DivStart(s8), .DivSigned(g_sgn),
      .RegAOut(g_a[7:0]), .RegBOut(g_b[7:0]),
      .DivBusy(busy8), .DivDone(done8), .Div0(z8), .HI(hi8), .LO(lo8));

   div_seq #(.WIDTH(16)) u_dut16 (
      .clk(clk), .reset(reset), .DivStart(s16), .DivSigned(g_sgn),
      .RegAOut(g_a[15:0]), .RegBOut(g_b[15:0]),
      .DivBusy(busy16), .DivDone(done16), .Div0(z16), .HI(hi16), .LO(lo16));

   div_seq #(.WIDTH(32)) u_dut32 (
      .clk(clk), .reset(reset), .DivStart(s32), .DivSigned(g_sgn),
      .RegAOut(g_a[31:0]), .RegBOut(g_b[31:0]),
      .DivBusy(busy32), .DivDone(done32), .Div0(z32), .HI(hi32), .LO(lo32));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Route the outputs of the instance under test onto one set of wide signals.
   always_comb begin
      g_busy = 1'b0;
      g_done = 1'b0;
      g_div0 = 1'b0;
      g_hi   = 64'd0;
      g_lo   = 64'd0;
      case (cur_w)
         8:  begin g_busy = busy8;  g_done = done8;  g_div0 = z8;  g_hi = {56'd0, hi8};  g_lo = {56'd0, lo8};  end
         16: begin g_busy = busy16; g_done = done16; g_div0 = z16; g_hi = {48'd0, hi16}; g_lo = {48'd0, lo16}; end
         32: begin g_busy = busy32; g_done = done32; g_div0 = z32; g_hi = {32'd0, hi32}; g_lo = {32'd0, lo32}; end
         default: begin g_busy = 1'b0; end
      endcase
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: truncating division on w-bit values using 64-bit integer arithmetic.
   function automatic void ref_div(input int w, input bit sgn, input logic [63:0] a_in,
                                   input logic [63:0] b_in, output logic [63:0] q,
                                   output logic [63:0] r, output bit z);
      logic [63:0] m, a, b;
      longint sa, sb;
      m = (64'd1 << w) - 64'd1;
      a = a_in & m;
      b = b_in & m;
      z = (b == 64'd0);
      if (z) begin
         q = 64'd0;
         r = 64'd0;
      end else if (sgn) begin
         sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
         sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
         q = sa / sb;
         r = sa % sb;
         q = q & m;
         r = r & m;
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic check_zero(input string tag);
      check_eq({tag, "/busy"}, 64'(g_busy), 64'd0);
      check_eq({tag, "/done"}, 64'(g_done), 64'd0);
      check_eq({tag, "/div0"}, 64'(g_div0), 64'd0);
      check_eq({tag, "/hi"}, g_hi, 64'd0);
      check_eq({tag, "/lo"}, g_lo, 64'd0);
   endtask

   // Called at a negedge; start is sampled at the next posedge (E0).
   task automatic run_op(input bit sgn, input logic [63:0] a, input logic [63:0] b,
                         input int inj, input bit hold, input string tag);
      logic [63:0] eq, er;
      bit ez;
      int lat, busy_n;
      ref_div(cur_w, sgn, a, b, eq, er, ez);
      g_sgn = sgn; g_a = a; g_b = b; g_start = 1'b1;
      @(negedge clk);
      g_start = 1'b0;
      lat = 0;
      busy_n = 0;
      if (!ez) check_eq({tag, "/div0_clr"}, 64'(g_div0), 64'd0);
      while (!g_done && lat <= cur_w + 4) begin
         if (g_busy) busy_n++;
         if (lat == inj) begin
            g_start = 1'b1;
            g_sgn = 1'($urandom);
            g_a = {$urandom, $urandom};
            g_b = 64'd0;
         end else begin
            g_start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      g_start = 1'b0;
      check_eq({tag, "/done"}, 64'(g_done), 64'd1);
      check_eq({tag, "/lat"}, 64'(lat), ez ? 64'd0 : 64'(cur_w + 1));
      check_eq({tag, "/busy_cyc"}, 64'(busy_n), ez ? 64'd0 : 64'(cur_w + 1));
      check_eq({tag, "/busy_end"}, 64'(g_busy), 64'd0);
      check_eq({tag, "/lo"}, g_lo, eq);
      check_eq({tag, "/hi"}, g_hi, er);
      check_eq({tag, "/div0"}, 64'(g_div0), 64'(ez));
      if (hold) begin
         @(negedge clk);
         check_eq({tag, "/pulse"}, 64'(g_done), 64'd0);
         check_eq({tag, "/hold_lo"}, g_lo, eq);
         check_eq({tag, "/hold_hi"}, g_hi, er);
         check_eq({tag, "/hold_div0"}, 64'(g_div0), 64'(ez));
      end
   endtask

   task automatic reset_mid();
      bit seen;
      cur_w = 32;
      g_sgn = 1'b0; g_a = 64'd1000; g_b = 64'd7; g_start = 1'b1;
      @(negedge clk);
      g_start = 1'b0;
      repeat (9) @(negedge clk);
      // Reset and a fresh start at the same edge: reset must win.
      reset = 1'b1;
      g_start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      g_start = 1'b0;
      check_zero("rst_mid");
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (g_done || g_busy) seen = 1'b1;
      end
      check_eq("rst_no_done", 64'(seen), 64'd0);
   endtask

   initial begin
      int widths[3];
      logic [63:0] b;
      widths = '{8, 16, 32};
      errors = 0;
      checks = 0;
      reset = 1'b1;
      g_start = 1'b0; g_sgn = 1'b0; g_a = 64'd0; g_b = 64'd0;
      cur_w = 32;
      repeat (3) @(negedge clk);
      foreach (widths[i]) begin
         cur_w = widths[i];
         #1;
         check_zero($sformatf("reset_w%0d", widths[i]));
      end
      reset = 1'b0;
      @(negedge clk);

      cur_w = 32;
      run_op(1'b1, 64'd7, 64'd2, -1, 1'b1, "s7_2");
      run_op(1'b0, 64'hFFFF_FFFF, 64'h10, -1, 1'b0, "u_ffff_10");
      run_op(1'b1, 64'hFFFF_FFF9, 64'd2, -1, 1'b0, "sm7_2");
      run_op(1'b1, 64'd7, 64'hFFFF_FFFE, -1, 1'b0, "s7_m2");
      run_op(1'b1, 64'hFFFF_FFF9, 64'hFFFF_FFFE, -1, 1'b1, "sm7_m2");
      run_op(1'b1, 64'h8000_0000, 64'hFFFF_FFFF, -1, 1'b1, "smin_m1");
      run_op(1'b0, 64'h8000_0000, 64'hFFFF_FFFF, -1, 1'b1, "umin_m1");
      run_op(1'b0, 64'd5, 64'd9, -1, 1'b1, "u5_9");
      run_op(1'b0, 64'd42, 64'd0, -1, 1'b1, "div0");
      run_op(1'b0, 64'd8, 64'd4, -1, 1'b1, "u8_4");
      run_op(1'b0, 64'd1000, 64'd3, 5, 1'b1, "inject");
      reset_mid();
      @(negedge clk);

      cur_w = 8;
      run_op(1'b1, 64'h80, 64'd3, -1, 1'b1, "w8_min_3");
      run_op(1'b1, 64'h80, 64'hFF, -1, 1'b1, "w8_min_m1");
      cur_w = 16;
      run_op(1'b0, 64'hFFFF, 64'hFF, -1, 1'b1, "w16_ffff_ff");
      run_op(1'b1, 64'hFFF9, 64'd2, -1, 1'b1, "w16_m7_2");

      foreach (widths[i]) begin
         cur_w = widths[i];
         for (int k = 0; k < 25; k++) begin
            case ($urandom_range(0, 7))
               0: b = 64'd0;
               1: b = 64'd1;
               2: b = 64'hFFFF_FFFF_FFFF_FFFF;
               3: b = 64'($urandom_range(1, 15));
               default: b = {$urandom, $urandom};
            endcase
            run_op(1'($urandom_range(0, 1)), {$urandom, $urandom}, b, -1, (k % 5) == 0,
                   $sformatf("rand_w%0d_%0d", widths[i], k));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
